// File: rtl/draw_sprites_pkg.sv
// Shared types and constants for the sprite overlay pipeline.
// Imported by the timing interface, the address generator and the top.
package draw_pkg;

    localparam int COLOR_W = 12;
    localparam int CNT_W   = 11;

    localparam logic [COLOR_W-1:0] KEY_DEFAULT = 12'hF0F;

    typedef enum logic [1:0] {
        ROT_UP    = 2'd0,
        ROT_RIGHT = 2'd1,
        ROT_DOWN  = 2'd2,
        ROT_LEFT  = 2'd3
    } rot_t;

    typedef struct packed {
        logic [CNT_W-1:0]   hcount;
        logic [CNT_W-1:0]   vcount;
        logic               hsync;
        logic               vsync;
        logic               hblnk;
        logic               vblnk;
        logic [COLOR_W-1:0] rgb;
    } vid_t;

endpackage

// File: rtl/draw_sprites_if.sv
// XGA timing bus: counters, syncs, blanking and one pixel colour.
// The master drives the bus, slaves only observe it.
interface draw_sprites_if;
    import draw_pkg::*;

    logic [CNT_W-1:0]   hcount;
    logic [CNT_W-1:0]   vcount;
    logic               hsync;
    logic               vsync;
    logic               hblnk;
    logic               vblnk;
    logic [COLOR_W-1:0] rgb;

    modport master (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

    modport slave (
        input hcount, vcount, hsync, vsync, hblnk, vblnk, rgb
    );

endinterface

// File: rtl/draw_sprites_addr_gen.sv
// One sprite channel: frame-start shadow, window test, rotation
// transform and the registered ROM address.
module sprite_addr_gen
    import draw_pkg::*;
#(
    parameter int SPR_W  = 64,
    parameter int ADDR_W = 12
) (
    input  logic              pclk,
    input  logic              rst,
    draw_sprites_if.slave     vid,
    input  logic [CNT_W-1:0]  xpos,
    input  logic [CNT_W-1:0]  ypos,
    input  logic [1:0]        rotation,
    input  logic              visible,
    output logic [ADDR_W-1:0] pixel_addr,
    output logic              hit
);

    localparam int LW = ADDR_W / 2;
    localparam logic [CNT_W:0] SPAN = (CNT_W + 1)'(SPR_W);

    logic [CNT_W-1:0]  sh_x;
    logic [CNT_W-1:0]  sh_y;
    rot_t              sh_rot;
    logic              sh_vis;
    logic              frame_start;
    logic              in_x;
    logic              in_y;
    logic              hit_now;
    logic [LW-1:0]     lx;
    logic [LW-1:0]     ly;
    logic [LW-1:0]     mx;
    logic [LW-1:0]     my;
    logic [ADDR_W-1:0] addr_now;

    assign frame_start = (vid.hcount == '0) && (vid.vcount == '0);

    // Placement is sampled once per frame so a frame never tears
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            sh_x   <= '0;
            sh_y   <= '0;
            sh_rot <= ROT_UP;
            sh_vis <= 1'b0;
        end else if (frame_start) begin
            sh_x   <= xpos;
            sh_y   <= ypos;
            sh_rot <= rot_t'(rotation);
            sh_vis <= visible;
        end
    end

    // Window bounds use one extra bit so a sprite near 2047 never wraps
    always_comb begin
        in_x = ({1'b0, vid.hcount} >= {1'b0, sh_x}) &&
               ({1'b0, vid.hcount} <  ({1'b0, sh_x} + SPAN));
        in_y = ({1'b0, vid.vcount} >= {1'b0, sh_y}) &&
               ({1'b0, vid.vcount} <  ({1'b0, sh_y} + SPAN));
        hit_now = sh_vis && in_x && in_y;
    end

    // Local coords are only meaningful inside the window; W-1-c == ~c
    assign lx = LW'(vid.hcount - sh_x);
    assign ly = LW'(vid.vcount - sh_y);
    assign mx = ~lx;
    assign my = ~ly;

    // Rotation picks which local axis becomes the ROM row
    always_comb begin
        addr_now = '0;
        unique case (sh_rot)
            ROT_UP:    addr_now = {ly, lx};
            ROT_RIGHT: addr_now = {mx, ly};
            ROT_DOWN:  addr_now = {my, mx};
            ROT_LEFT:  addr_now = {lx, my};
        endcase
    end

    // Address goes to the ROM; hit travels alongside to meet its data
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            pixel_addr <= '0;
            hit        <= 1'b0;
        end else begin
            pixel_addr <= hit_now ? addr_now : '0;
            hit        <= hit_now;
        end
    end

endmodule

// File: rtl/draw_sprites.sv
// Sprite overlay: N_SPR channels over a background, index priority,
// colour-key transparency and per-frame overlap flags.
module draw_sprites
    import draw_pkg::*;
#(
    parameter int                 N_SPR   = 2,
    parameter int                 SPR_W   = 64,
    parameter logic [COLOR_W-1:0] KEY_RGB = KEY_DEFAULT,
    parameter int                 ADDR_W  = 12
) (
    input  logic                      pclk,
    input  logic                      rst,
    input  logic [CNT_W-1:0]          hcount_in,
    input  logic [CNT_W-1:0]          vcount_in,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      hblnk_in,
    input  logic                      vblnk_in,
    input  logic [COLOR_W-1:0]        rgb_in,
    input  logic [N_SPR*CNT_W-1:0]    xpos,
    input  logic [N_SPR*CNT_W-1:0]    ypos,
    input  logic [N_SPR*2-1:0]        rotation,
    input  logic [N_SPR-1:0]          visible,
    output logic [N_SPR*ADDR_W-1:0]   pixel_addr,
    input  logic [N_SPR*COLOR_W-1:0]  rgb_pixel,
    output logic [CNT_W-1:0]          hcount_out,
    output logic [CNT_W-1:0]          vcount_out,
    output logic                      hsync_out,
    output logic                      vsync_out,
    output logic                      hblnk_out,
    output logic                      vblnk_out,
    output logic [COLOR_W-1:0]        rgb_out,
    output logic [N_SPR-1:0]          collision
);

    draw_sprites_if vin ();

    assign vin.hcount = hcount_in;
    assign vin.vcount = vcount_in;
    assign vin.hsync  = hsync_in;
    assign vin.vsync  = vsync_in;
    assign vin.hblnk  = hblnk_in;
    assign vin.vblnk  = vblnk_in;
    assign vin.rgb    = rgb_in;

    vid_t               d1;
    vid_t               d2;
    vid_t               d3;
    logic [N_SPR-1:0]   hit_d1;
    logic [N_SPR-1:0]   hit_d2;
    logic [N_SPR-1:0]   opaque;
    logic [N_SPR-1:0]   overlap;
    logic [N_SPR-1:0]   sticky;
    logic [COLOR_W-1:0] pix_sel;
    logic [COLOR_W-1:0] rgb_q;
    logic               frame_start;

    assign frame_start = (vin.hcount == '0) && (vin.vcount == '0);

    for (genvar i = 0; i < N_SPR; i++) begin : g_spr
        sprite_addr_gen #(
            .SPR_W  (SPR_W),
            .ADDR_W (ADDR_W)
        ) u_addr (
            .pclk       (pclk),
            .rst        (rst),
            .vid        (vin),
            .xpos       (xpos[i*CNT_W +: CNT_W]),
            .ypos       (ypos[i*CNT_W +: CNT_W]),
            .rotation   (rotation[i*2 +: 2]),
            .visible    (visible[i]),
            .pixel_addr (pixel_addr[i*ADDR_W +: ADDR_W]),
            .hit        (hit_d1[i])
        );
    end

    // Lowest opaque index wins; walking down lets index 0 land last
    always_comb begin
        opaque  = '0;
        pix_sel = d2.rgb;
        for (int i = N_SPR - 1; i >= 0; i--) begin
            opaque[i] = hit_d2[i] &&
                (rgb_pixel[i*COLOR_W +: COLOR_W] != KEY_RGB);
            if (opaque[i]) begin
                pix_sel = rgb_pixel[i*COLOR_W +: COLOR_W];
            end
        end
        overlap = ((opaque & (opaque - N_SPR'(1))) != '0) ? opaque : '0;
    end

    // Timing rides three registers; colour is resolved on the last one
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            d1     <= '0;
            d2     <= '0;
            d3     <= '0;
            hit_d2 <= '0;
            rgb_q  <= '0;
        end else begin
            d1 <= '{hcount: vin.hcount, vcount: vin.vcount,
                    hsync:  vin.hsync,  vsync:  vin.vsync,
                    hblnk:  vin.hblnk,  vblnk:  vin.vblnk,
                    rgb:    vin.rgb};
            d2     <= d1;
            d3     <= d2;
            hit_d2 <= hit_d1;
            rgb_q  <= (d2.hblnk || d2.vblnk) ? '0 : pix_sel;
        end
    end

    // Overlaps accumulate per frame; the frame-start hit seeds the new one
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            sticky    <= '0;
            collision <= '0;
        end else if (frame_start) begin
            collision <= sticky;
            sticky    <= overlap;
        end else begin
            sticky <= sticky | overlap;
        end
    end

    assign hcount_out = d3.hcount;
    assign vcount_out = d3.vcount;
    assign hsync_out  = d3.hsync;
    assign vsync_out  = d3.vsync;
    assign hblnk_out  = d3.hblnk;
    assign vblnk_out  = d3.vblnk;
    assign rgb_out    = rgb_q;

endmodule

// File: tb/tb_draw_sprites.sv
// Randomised bench for draw_sprites with a per-pixel reference model
// and a synchronous sprite ROM model.
module tb_draw_sprites;

    localparam int          N     = 2;
    localparam int          SPR_W = 64;
    localparam logic [11:0] KEY   = 12'hF0F;

    typedef struct packed {
        logic [1:0]  hit;
        logic [23:0] addr;
        logic [11:0] rgb;
        logic [25:0] tim;
        logic        blank;
    } rec_t;

    logic        pclk = 1'b0;
    logic        rst;
    logic [21:0] xpos;
    logic [21:0] ypos;
    logic [3:0]  rotation;
    logic [1:0]  visible;
    logic [23:0] pixel_addr;
    logic [23:0] rgb_pixel = '0;
    logic [10:0] hcount_out;
    logic [10:0] vcount_out;
    logic        hsync_out;
    logic        vsync_out;
    logic        hblnk_out;
    logic        vblnk_out;
    logic [11:0] rgb_out;
    logic [1:0]  collision;
    logic [25:0] tim_out;

    int n_chk;
    int n_pass;

    rec_t        p1;
    rec_t        p2;
    logic [1:0]  m_sticky;
    logic [1:0]  m_col;
    logic [23:0] m_addr;
    logic [11:0] m_rgb;
    logic [25:0] m_tim;
    int          msx [N];
    int          msy [N];
    int          msr [N];
    bit          msv [N];

    draw_sprites_if vid ();

    always #5 pclk = ~pclk;

    assign tim_out = {hcount_out, vcount_out, hsync_out,
                      vsync_out, hblnk_out, vblnk_out};

    draw_sprites dut (
        .pclk       (pclk),
        .rst        (rst),
        .hcount_in  (vid.hcount),
        .vcount_in  (vid.vcount),
        .hsync_in   (vid.hsync),
        .vsync_in   (vid.vsync),
        .hblnk_in   (vid.hblnk),
        .vblnk_in   (vid.vblnk),
        .rgb_in     (vid.rgb),
        .xpos       (xpos),
        .ypos       (ypos),
        .rotation   (rotation),
        .visible    (visible),
        .pixel_addr (pixel_addr),
        .rgb_pixel  (rgb_pixel),
        .hcount_out (hcount_out),
        .vcount_out (vcount_out),
        .hsync_out  (hsync_out),
        .vsync_out  (vsync_out),
        .hblnk_out  (hblnk_out),
        .vblnk_out  (vblnk_out),
        .rgb_out    (rgb_out),
        .collision  (collision)
    );

    // Sprite 0: address as colour, bottom rows (addr >= 3584) keyed.
    // Sprite 1: address xor 5A5, keyed when the low nibble becomes 0.
    function automatic logic [11:0] rom_val(input int i, input logic [11:0] a);
        logic [11:0] d;
        if (i == 0) begin
            return (a[11:9] == 3'b111) ? KEY : a;
        end
        d = a ^ 12'h5A5;
        return (d[3:0] == 4'h0) ? KEY : d;
    endfunction

    // Synchronous ROM: data one clock after the address
    always @(posedge pclk) begin
        for (int i = 0; i < N; i++) begin
            rgb_pixel[i*12 +: 12] <= rom_val(i, pixel_addr[i*12 +: 12]);
        end
    end

    function automatic int ref_addr(input int r, input int x, input int y);
        case (r)
            0:       return y * SPR_W + x;
            1:       return (SPR_W - 1 - x) * SPR_W + y;
            2:       return (SPR_W - 1 - y) * SPR_W + (SPR_W - 1 - x);
            default: return x * SPR_W + (SPR_W - 1 - y);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        p1 = '0;
        p2 = '0;
        m_sticky = '0;
        m_col = '0;
        for (int i = 0; i < N; i++) begin
            msx[i] = 0;
            msy[i] = 0;
            msr[i] = 0;
            msv[i] = 1'b0;
        end
    endtask

    // Evaluated at each clock edge with the inputs the DUT samples there
    task automatic model_edge();
        rec_t       cur;
        logic [1:0] opq;
        logic [1:0] evt;
        int         h;
        int         v;
        h = int'(vid.hcount);
        v = int'(vid.vcount);
        cur = '0;
        cur.rgb = vid.rgb;
        cur.blank = vid.hblnk | vid.vblnk;
        cur.tim = {vid.hcount, vid.vcount, vid.hsync,
                   vid.vsync, vid.hblnk, vid.vblnk};
        for (int i = 0; i < N; i++) begin
            if (msv[i] && h >= msx[i] && h < msx[i] + SPR_W &&
                v >= msy[i] && v < msy[i] + SPR_W) begin
                cur.hit[i] = 1'b1;
                cur.addr[i*12 +: 12] = 12'(ref_addr(msr[i], h - msx[i], v - msy[i]));
            end
        end
        opq = '0;
        m_rgb = p2.rgb;
        for (int i = N - 1; i >= 0; i--) begin
            if (p2.hit[i] && rom_val(i, p2.addr[i*12 +: 12]) != KEY) begin
                opq[i] = 1'b1;
                m_rgb = rom_val(i, p2.addr[i*12 +: 12]);
            end
        end
        if (p2.blank) m_rgb = '0;
        evt = ($countones(opq) >= 2) ? opq : 2'b00;
        if (h == 0 && v == 0) begin
            m_col = m_sticky;
            m_sticky = evt;
            for (int i = 0; i < N; i++) begin
                msx[i] = int'(xpos[i*11 +: 11]);
                msy[i] = int'(ypos[i*11 +: 11]);
                msr[i] = int'(rotation[i*2 +: 2]);
                msv[i] = visible[i];
            end
        end else begin
            m_sticky = m_sticky | evt;
        end
        m_addr = cur.addr;
        m_tim = p2.tim;
        p2 = p1;
        p1 = cur;
    endtask

    task automatic tick();
        @(posedge pclk);
        model_edge();
        #1;
        check("pixel_addr", pixel_addr, m_addr);
        check("rgb_out", rgb_out, m_rgb);
        check("timing", tim_out, m_tim);
        check("collision", collision, m_col);
    endtask

    task automatic drive(input int h, input int v,
                         input bit hb = 1'b0, input bit vb = 1'b0);
        vid.hcount = 11'(h);
        vid.vcount = 11'(v);
        vid.hsync = 1'($urandom);
        vid.vsync = 1'($urandom);
        vid.hblnk = hb;
        vid.vblnk = vb;
        vid.rgb = 12'($urandom);
    endtask

    task automatic set_spr(input int i, input int x, input int y,
                           input int r, input bit vis);
        xpos[i*11 +: 11] = 11'(x);
        ypos[i*11 +: 11] = 11'(y);
        rotation[i*2 +: 2] = 2'(r);
        visible[i] = vis;
    endtask

    task automatic latch();
        drive(0, 0);
        tick();
    endtask

    // Drive one pixel, flush it through, compare the resolved colour
    task automatic probe_rgb(input string tag, input int h, input int v,
                             input bit hb, input logic [11:0] exp,
                             input bit use_bg);
        logic [11:0] want;
        drive(h, v, hb, 1'b0);
        want = use_bg ? vid.rgb : exp;
        tick();
        drive(1000, 700);
        tick();
        tick();
        check(tag, rgb_out, want);
    endtask

    int rot_exp [4];

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        xpos = '0;
        ypos = '0;
        rotation = '0;
        visible = '0;
        vid.hcount = '0;
        vid.vcount = '0;
        vid.hsync = 1'b0;
        vid.vsync = 1'b0;
        vid.hblnk = 1'b0;
        vid.vblnk = 1'b0;
        vid.rgb = '0;
        set_spr(0, 100, 100, 0, 1'b1);
        model_reset();
        repeat (3) @(posedge pclk);
        #1;
        check("rst_addr", pixel_addr, 0);
        check("rst_rgb", rgb_out, 0);
        check("rst_timing", tim_out, 0);
        check("rst_collision", collision, 0);
        rst = 1'b0;

        // Visible before any frame start: nothing drawn yet
        drive(110, 105);
        tick();
        check("pre_latch_addr", pixel_addr, 0);

        // Basic rot0 address and colour latency
        latch();
        drive(110, 105);
        tick();
        check("rot0_addr", pixel_addr[11:0], 330);
        drive(1000, 700);
        tick();
        tick();
        check("rot0_rgb", rgb_out, 12'h14A);

        // Rotations at local (1,0)
        rot_exp[1] = 3968;
        rot_exp[2] = 4094;
        rot_exp[3] = 127;
        for (int r = 1; r < 4; r++) begin
            set_spr(0, 0, 0, r, 1'b1);
            latch();
            drive(1, 0);
            tick();
            check($sformatf("rot%0d_addr", r), pixel_addr[11:0], rot_exp[r]);
        end

        // Two opaque sprites stacked
        set_spr(0, 200, 200, 0, 1'b1);
        set_spr(1, 200, 200, 0, 1'b1);
        latch();
        probe_rgb("overlap_rgb", 210, 210, 1'b0, 12'h28A, 1'b0);

        // Key colour handling; this latch also publishes the overlap
        set_spr(0, 200, 200, 2, 1'b1);
        set_spr(1, 200, 150, 0, 1'b1);
        latch();
        check("collision_11", collision, 2'b11);
        probe_rgb("key_over_spr1", 210, 205, 1'b0, 12'h86F, 1'b0);
        probe_rgb("key_over_bg", 205, 205, 1'b0, 12'h000, 1'b1);
        probe_rgb("hblnk_black", 210, 205, 1'b1, 12'h000, 1'b0);
        check("collision_held", collision, 2'b11);

        // Mid-frame move is ignored until the next frame start
        set_spr(0, 300, 300, 0, 1'b1);
        set_spr(1, 0, 0, 0, 1'b0);
        latch();
        set_spr(0, 500, 300, 0, 1'b1);
        drive(310, 310);
        tick();
        check("shadow_hold", pixel_addr[11:0], 650);

        // Right-edge sprite must not wrap onto column 0
        set_spr(0, 2020, 0, 0, 1'b1);
        latch();
        drive(10, 10);
        tick();
        check("no_wrap", pixel_addr[11:0], 0);
        drive(2030, 10);
        tick();
        check("edge_hit", pixel_addr[11:0], 650);
        drive(2047, 63);
        tick();

        // Reset in the middle of a frame
        set_spr(0, 300, 300, 0, 1'b1);
        latch();
        drive(310, 310);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_addr", pixel_addr, 0);
        check("mid_rst_rgb", rgb_out, 0);
        check("mid_rst_timing", tim_out, 0);
        check("mid_rst_collision", collision, 0);
        model_reset();
        repeat (2) @(posedge pclk);
        #1;
        rst = 1'b0;
        drive(310, 310);
        tick();
        check("post_rst_addr", pixel_addr, 0);
        drive(320, 320);
        tick();
        latch();
        drive(310, 310);
        tick();
        check("post_latch_addr", pixel_addr[11:0], 650);

        // Random frames
        for (int k = 0; k < 4000; k++) begin
            if (k % 97 == 0) begin
                for (int i = 0; i < N; i++) begin
                    set_spr(i,
                        ($urandom_range(0, 7) == 0) ? $urandom_range(1990, 2047)
                                                     : $urandom_range(0, 260),
                        $urandom_range(0, 260),
                        $urandom_range(0, 3),
                        $urandom_range(0, 3) != 0);
                end
                drive(0, 0);
            end else begin
                if ($urandom_range(0, 15) == 0) begin
                    set_spr($urandom_range(0, 1), $urandom_range(0, 2047),
                            $urandom_range(0, 2047), $urandom_range(0, 3),
                            1'($urandom));
                end
                if ($urandom_range(0, 31) == 0) begin
                    drive($urandom_range(1990, 2047), $urandom_range(0, 330),
                          $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
                end else begin
                    drive($urandom_range(0, 330), $urandom_range(0, 330),
                          $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0);
                end
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
